// File: rtl/seed_timer_if.sv
// Control/status bundle between the game FSM and seed_timer.
// Latency: none (wires only).
// Backpressure: none; levels and pulses only, there is no handshake.
//
// Signals:
//   i_RstCounter  clear count, flags and prescaler
//   i_ActCounter  level, high selects timed mode
//   i_RunFree     level, enables free-run counting outside timed mode
//   o_Count       current count (WIDTH bits)
//   o_Seed        free-run value captured on entry to timed mode
//   o_TwoSec      sticky interval-complete flag
//   o_DonePulse   one-cycle pulse on completion
// Modports: master = game FSM side, slave = seed_timer side.
interface seed_timer_if #(
    parameter int WIDTH = 12
);
    logic             i_RstCounter;
    logic             i_ActCounter;
    logic             i_RunFree;
    logic [WIDTH-1:0] o_Count;
    logic [WIDTH-1:0] o_Seed;
    logic             o_TwoSec;
    logic             o_DonePulse;

    modport master (
        output i_RstCounter,
        output i_ActCounter,
        output i_RunFree,
        input  o_Count,
        input  o_Seed,
        input  o_TwoSec,
        input  o_DonePulse
    );

    modport slave (
        input  i_RstCounter,
        input  i_ActCounter,
        input  i_RunFree,
        output o_Count,
        output o_Seed,
        output o_TwoSec,
        output o_DonePulse
    );
endinterface

// File: rtl/seed_timer.sv
// Free-running seed counter that doubles as a prescaled interval timer.
// Latency: o_TwoSec rises TERM_COUNT*DIV+1 clocks after i_ActCounter rises.
// Backpressure: none; all inputs are levels, sampled every clk_50M edge.
//
// Ports:
//   clk_50M   system clock
//   i_Reset   synchronous active-high reset, highest priority
//   bus       seed_timer_if.slave (controls in, count/seed/flags out)
// Parameters: WIDTH, CLK_HZ, TICK_HZ (DIV = CLK_HZ/TICK_HZ >= 2), TERM_COUNT.
// Build option: define SEED_TIMER_AUTORELOAD_EN to make the timed interval
// periodic (count reloads to 0 at TERM_COUNT, o_DonePulse every period).
module seed_timer #(
    parameter int WIDTH      = 12,
    parameter int CLK_HZ     = 50000000,
    parameter int TICK_HZ    = 2000,
    parameter int TERM_COUNT = 4000
) (
    input  logic          clk_50M,
    input  logic          i_Reset,
    seed_timer_if.slave   bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] TERM_M1    = WIDTH'(TERM_COUNT - 1);
`ifndef SEED_TIMER_AUTORELOAD_EN
    localparam logic [WIDTH-1:0] TERM       = WIDTH'(TERM_COUNT);
`endif

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] seed;
    logic             two_sec;
    logic             done_pulse;
    logic [PW-1:0]    presc;
    logic             act_q;
    logic             tick;

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            count      <= '0;
            seed       <= '0;
            two_sec    <= 1'b0;
            done_pulse <= 1'b0;
            presc      <= '0;
            act_q      <= 1'b0;
        end else begin
            // act_q tracks the level even during a clear, so a clear that
            // coincides with the rising edge swallows that start.
            act_q      <= bus.i_ActCounter;
            done_pulse <= 1'b0;

            if (bus.i_RstCounter) begin
                count   <= '0;
                two_sec <= 1'b0;
                presc   <= '0;
            end else if (bus.i_ActCounter && !act_q) begin
                seed    <= count;
                count   <= '0;
                presc   <= '0;
                two_sec <= 1'b0;
            end else if (bus.i_ActCounter) begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick) begin
`ifdef SEED_TIMER_AUTORELOAD_EN
                    if (count >= TERM_M1) begin
                        count      <= '0;
                        two_sec    <= 1'b1;
                        done_pulse <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
`else
                    // Saturate at TERM; the pulse fires only on the step
                    // that lands on TERM, so it cannot repeat.
                    if (count < TERM) begin
                        count <= count + 1'b1;
                        if (count == TERM_M1) begin
                            two_sec    <= 1'b1;
                            done_pulse <= 1'b1;
                        end
                    end
`endif
                end
            end else if (act_q) begin
                // First cycle out of timed mode: everything holds, the
                // prescaler is parked so the next interval starts clean.
                presc <= '0;
            end else if (bus.i_RunFree) begin
                count <= count + 1'b1;
            end
        end
    end

    assign bus.o_Count     = count;
    assign bus.o_Seed      = seed;
    assign bus.o_TwoSec    = two_sec;
    assign bus.o_DonePulse = done_pulse;

endmodule

// File: tb/tb_seed_timer.sv
// Directed self-checking bench for seed_timer (WIDTH=4, DIV=10, TERM_COUNT=5).
// Latency: n/a.
// Backpressure: n/a.
module tb_seed_timer;
    logic clk_50M = 1'b0;
    logic i_Reset;

    int checks = 0;
    int errors = 0;
    int exp_hold;

    always #5 clk_50M = ~clk_50M;

    seed_timer_if #(.WIDTH(4)) bus ();

    seed_timer #(
        .WIDTH      (4),
        .CLK_HZ     (1000),
        .TICK_HZ    (100),
        .TERM_COUNT (5)
    ) dut (
        .clk_50M (clk_50M),
        .i_Reset (i_Reset),
        .bus     (bus.slave)
    );

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk_50M);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        i_Reset          = 1'b1;
        bus.i_RstCounter = 1'b0;
        bus.i_ActCounter = 1'b0;
        bus.i_RunFree    = 1'b0;

        // Reset and idle hold
        step(3);
        check("rst_count", bus.o_Count, 0);
        check("rst_seed", bus.o_Seed, 0);
        check("rst_twosec", bus.o_TwoSec, 0);
        check("rst_pulse", bus.o_DonePulse, 0);
        i_Reset = 1'b0;
        step(20);
        check("idle_count", bus.o_Count, 0);
        check("idle_seed", bus.o_Seed, 0);
        check("idle_twosec", bus.o_TwoSec, 0);
        check("idle_pulse", bus.o_DonePulse, 0);

        // Free-run wraps past 15
        bus.i_RunFree = 1'b1;
        step(18);
        check("free_wrap_count", bus.o_Count, 2);
        check("free_twosec", bus.o_TwoSec, 0);
        step(7);
        check("free_count9", bus.o_Count, 9);

        // Timed run: seed capture and tick cadence
        bus.i_ActCounter = 1'b1;
        step(1);
        check("start_seed", bus.o_Seed, 9);
        check("start_count", bus.o_Count, 0);
        check("start_twosec", bus.o_TwoSec, 0);
        step(9);
        check("pre_tick1", bus.o_Count, 0);
        step(1);
        check("tick1", bus.o_Count, 1);
        for (int k = 2; k <= 4; k++) begin
            step(10);
            check("tick_k", bus.o_Count, k);
        end
        step(9);
        check("pre_done_count", bus.o_Count, 4);
        check("pre_done_twosec", bus.o_TwoSec, 0);
        check("pre_done_pulse", bus.o_DonePulse, 0);
        step(1);
`ifndef SEED_TIMER_AUTORELOAD_EN
        check("done_count", bus.o_Count, 5);
        check("done_twosec", bus.o_TwoSec, 1);
        check("done_pulse", bus.o_DonePulse, 1);
        step(1);
        check("pulse_width", bus.o_DonePulse, 0);
        for (int i = 0; i < 100; i++) begin
            step(1);
            check("sat_count", bus.o_Count, 5);
            check("sat_pulse", bus.o_DonePulse, 0);
        end
        exp_hold = 5;
`else
        check("done_count", bus.o_Count, 0);
        check("done_twosec", bus.o_TwoSec, 1);
        check("done_pulse", bus.o_DonePulse, 1);
        step(1);
        check("pulse_width", bus.o_DonePulse, 0);
        step(9);
        check("reload_tick1", bus.o_Count, 1);
        for (int k = 2; k <= 4; k++) begin
            step(10);
            check("reload_tick_k", bus.o_Count, k);
        end
        step(10);
        check("reload2_count", bus.o_Count, 0);
        check("reload2_pulse", bus.o_DonePulse, 1);
        step(1);
        check("reload2_width", bus.o_DonePulse, 0);
        step(49);
        check("reload3_count", bus.o_Count, 0);
        check("reload3_pulse", bus.o_DonePulse, 1);
        check("reload3_twosec", bus.o_TwoSec, 1);
        step(1);
        check("reload3_width", bus.o_DonePulse, 0);
        exp_hold = 0;
`endif

        // Leave timed mode with free-run off: everything holds
        bus.i_ActCounter = 1'b0;
        bus.i_RunFree    = 1'b0;
        step(1);
        check("leave_count", bus.o_Count, exp_hold);
        check("leave_twosec", bus.o_TwoSec, 1);
        check("leave_seed", bus.o_Seed, 9);
        step(5);
        check("hold_count", bus.o_Count, exp_hold);

        // Clear at tick 3 of a new timed run
        bus.i_ActCounter = 1'b1;
        step(1);
        check("restart_seed", bus.o_Seed, exp_hold);
        check("restart_twosec", bus.o_TwoSec, 0);
        step(30);
        check("tick3", bus.o_Count, 3);
        bus.i_RstCounter = 1'b1;
        step(1);
        bus.i_RstCounter = 1'b0;
        check("clr_count", bus.o_Count, 0);
        check("clr_twosec", bus.o_TwoSec, 0);
        check("clr_seed", bus.o_Seed, exp_hold);
        step(9);
        check("clr_pre_tick", bus.o_Count, 0);
        step(1);
        check("clr_tick1", bus.o_Count, 1);
        step(30);
        check("clr_tick4", bus.o_Count, 4);

        // Reset mid-interval, then a fresh start with i_ActCounter held
        i_Reset = 1'b1;
        step(1);
        check("mid_rst_count", bus.o_Count, 0);
        check("mid_rst_seed", bus.o_Seed, 0);
        check("mid_rst_twosec", bus.o_TwoSec, 0);
        check("mid_rst_pulse", bus.o_DonePulse, 0);
        i_Reset = 1'b0;
        step(1);
        check("post_rst_seed", bus.o_Seed, 0);
        check("post_rst_count", bus.o_Count, 0);
        step(9);
        check("post_rst_pre_tick", bus.o_Count, 0);
        step(1);
        check("post_rst_tick1", bus.o_Count, 1);

        // Leave timed mode into free-run: hold one cycle, then count
        bus.i_ActCounter = 1'b0;
        bus.i_RunFree    = 1'b1;
        step(1);
        check("fall_hold", bus.o_Count, 1);
        step(6);
        check("fall_free", bus.o_Count, 7);

        // Clear coincident with the i_ActCounter rise: no capture, no late start
        bus.i_ActCounter = 1'b1;
        bus.i_RstCounter = 1'b1;
        step(1);
        bus.i_RstCounter = 1'b0;
        check("coin_count", bus.o_Count, 0);
        check("coin_seed", bus.o_Seed, 0);
        check("coin_twosec", bus.o_TwoSec, 0);
        step(9);
        check("coin_pre_tick", bus.o_Count, 0);
        check("coin_seed_later", bus.o_Seed, 0);
        step(1);
        check("coin_tick1", bus.o_Count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
